cpu_mem_bridge: RTL and testbench

- Sits between the `cpu` mask-style memory port (addr/rmask/wmask/rdata/wdata/resp) and a downstream valid/ready memory subsystem.
- Captures one CPU request at a time and issues it as a single word request on the downstream request channel.
- Waits for the downstream response and returns it to the CPU as a one-cycle `resp` pulse.
- Flags protocol violations and response timeouts on a sticky error output, which the bench treats like `mem_itf.error`.

---
 rtl/cpu_mem_bridge_pkg.sv | 26 ++
 rtl/cpu_mem_bridge_timer.sv | 31 +++
 rtl/cpu_mem_bridge.sv | 148 ++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_bridge_pkg.sv
// Shared types for the CPU mask-port to valid/ready memory bridge.
package cpu_mem_bridge_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_MASK_W = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    RESP
  } state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_MASK_W-1:0] mask;
    logic [DEF_DATA_W-1:0] wdata;
    logic                  we;
  } req_t;

  function automatic logic [DEF_ADDR_W-1:0] word_align(input logic [DEF_ADDR_W-1:0] addr);
    return {addr[DEF_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu_mem_bridge_timer.sv
// Clearable saturating response timer; o_expire_c is high once the count reaches TIMEOUT_CYCLES-1.
import cpu_mem_bridge_pkg::*;

module cpu_mem_bridge_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != LAST)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expire_c = (r_count == LAST);

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridges one CPU mask-style request at a time onto a valid/ready memory channel.
// Optional misaligned-address rejection: define CPU_MEM_BRIDGE_ALIGN_CHECK_EN.
import cpu_mem_bridge_pkg::*;

module cpu_mem_bridge #(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W/8-1:0] cpu_rmask,
  input  logic [DATA_W/8-1:0] cpu_wmask,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_resp,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_we,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [DATA_W/8-1:0] req_mask,
  output logic [DATA_W-1:0]   req_wdata,
  input  logic                rsp_valid,
  input  logic [DATA_W-1:0]   rsp_rdata,
  output logic                error
);

  state_t              r_state, w_state_nxt;
  req_t                r_req, w_req_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_resp, w_resp_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_error, w_error_nxt;
  logic                w_cpu_req;
  logic                w_misaligned;
  logic                w_timer_clr;
  logic                w_timer_en;
  logic                w_timeout;

  assign w_cpu_req = |(cpu_rmask | cpu_wmask);

`ifdef CPU_MEM_BRIDGE_ALIGN_CHECK_EN
  assign w_misaligned = |cpu_addr[1:0];
`else
  assign w_misaligned = 1'b0;
`endif

  // Timer only runs while waiting for a response; it restarts on every entry to WAIT_RSP.
  assign w_timer_clr = (r_state != WAIT_RSP);
  assign w_timer_en  = (r_state == WAIT_RSP) && !rsp_valid;

  cpu_mem_bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_timer_clr),
    .i_en      (w_timer_en),
    .o_expire_c(w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_valid <= 1'b0;
      r_resp  <= 1'b0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_valid <= w_valid_nxt;
      r_resp  <= w_resp_nxt;
      r_rdata <= w_rdata_nxt;
      r_error <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_valid_nxt = r_valid;
    w_resp_nxt  = 1'b0;
    w_rdata_nxt = r_rdata;
    w_error_nxt = r_error;

    // CPU must wait for resp before issuing again; stray responses are protocol errors.
    if ((r_state != IDLE) && w_cpu_req) w_error_nxt = 1'b1;
    if ((r_state != WAIT_RSP) && rsp_valid) w_error_nxt = 1'b1;

    unique case (r_state)
      IDLE: begin
        if (w_cpu_req) begin
          if ((|cpu_rmask) && (|cpu_wmask)) w_error_nxt = 1'b1;
          if (w_misaligned) begin
            w_error_nxt = 1'b1;
            w_resp_nxt  = 1'b1;
            w_rdata_nxt = '0;
            w_state_nxt = RESP;
          end else begin
            w_req_nxt.addr  = word_align(cpu_addr);
            w_req_nxt.we    = |cpu_wmask;
            w_req_nxt.mask  = (|cpu_wmask) ? cpu_wmask : cpu_rmask;
            w_req_nxt.wdata = cpu_wdata;
            w_valid_nxt     = 1'b1;
            w_state_nxt     = REQ;
          end
        end
      end
      REQ: begin
        if (req_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          w_resp_nxt  = 1'b1;
          w_rdata_nxt = r_req.we ? '0 : rsp_rdata;
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_error_nxt = 1'b1;
          w_resp_nxt  = 1'b1;
          w_rdata_nxt = '0;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign cpu_rdata = r_rdata;
  assign cpu_resp  = r_resp;
  assign req_valid = r_valid;
  assign req_we    = r_req.we;
  assign req_addr  = r_req.addr;
  assign req_mask  = r_req.mask;
  assign req_wdata = r_req.wdata;
  assign error     = r_error;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Scoreboard bench for cpu_mem_bridge: random CPU traffic against a reference memory and a downstream memory model.
module tb_cpu_mem_bridge;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_rmask;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_resp;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        error;

  always #5 clk = ~clk;

  cpu_mem_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_rmask(cpu_rmask), .cpu_wmask(cpu_wmask), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_resp(cpu_resp),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_mask(req_mask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .error(error)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        we;
  } exp_req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_rsp_t;

  exp_req_t    exp_req_q[$];
  exp_rsp_t    exp_rsp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] ds_mem[logic [31:0]];

  int n_chk  = 0;
  int n_fail = 0;
  bit exp_err = 1'b0;
  int rdy_fix = 0;
  int rsp_fix = 0;
  bit ds_no_rsp = 1'b0;
  bit spur_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ds_rd(input logic [31:0] a);
    return ds_mem.exists(a) ? ds_mem[a] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ref_mem[a] = d;
    ds_mem[a]  = d;
  endtask

  // Downstream memory: accepts requests after a chosen stall, answers after a chosen delay.
  initial begin : downstream
    int          phase;
    int          cnt;
    exp_req_t    cur;
    exp_req_t    act;
    logic [31:0] rd;
    phase = 0; cnt = 0; rd = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      if (!rst_n) begin
        phase = 0;
      end else begin
        case (phase)
          0: begin
            if (spur_req) begin
              rsp_valid = 1'b1;
              rsp_rdata = $urandom;
              spur_req  = 1'b0;
            end else if (req_valid) begin
              act.addr = req_addr; act.mask = req_mask; act.wdata = req_wdata; act.we = req_we;
              if (exp_req_q.size() == 0) begin
                chk("req_unexpected", 32'(req_valid), 32'h0);
                cur = act;
              end else begin
                cur = exp_req_q.pop_front();
                chk("req_we", 32'(req_we), 32'(cur.we));
                chk("req_addr", req_addr, cur.addr);
                chk("req_mask", 32'(req_mask), 32'(cur.mask));
                chk("req_wdata", req_wdata, cur.wdata);
              end
              cnt = (rdy_fix >= 0) ? rdy_fix : int'($urandom_range(0, 3));
              if (cnt == 0) begin req_ready = 1'b1; phase = 3; end
              else phase = 1;
            end
          end
          1: begin
            chk("req_valid_hold", 32'(req_valid), 32'h1);
            chk("req_addr_hold", req_addr, cur.addr);
            chk("req_mask_hold", 32'(req_mask), 32'(cur.mask));
            chk("req_wdata_hold", req_wdata, cur.wdata);
            chk("req_we_hold", 32'(req_we), 32'(cur.we));
            cnt--;
            if (cnt == 0) begin req_ready = 1'b1; phase = 3; end
          end
          3: begin
            chk("req_valid_drop", 32'(req_valid), 32'h0);
            if (act.we) begin
              ds_mem[act.addr] = merge(ds_rd(act.addr), act.wdata, act.mask);
              rd = $urandom;
            end else begin
              rd = ds_rd(act.addr);
            end
            if (ds_no_rsp) begin
              phase = 0;
            end else begin
              cnt = (rsp_fix >= 0) ? rsp_fix : int'($urandom_range(0, 4));
              if (cnt == 0) begin rsp_valid = 1'b1; rsp_rdata = rd; phase = 0; end
              else phase = 2;
            end
          end
          2: begin
            cnt--;
            if (cnt == 0) begin rsp_valid = 1'b1; rsp_rdata = rd; phase = 0; end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  exp_rsp_t mon_e;

  // Response monitor: every cpu_resp pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && cpu_resp) begin
      if (exp_rsp_q.size() == 0) begin
        chk("resp_unexpected", 32'(cpu_resp), 32'h0);
      end else begin
        mon_e = exp_rsp_q.pop_front();
        chk("cpu_rdata", cpu_rdata, mon_e.rdata);
        chk("error_at_resp", 32'(error), 32'(mon_e.err));
      end
    end
  end

  task automatic check_reset_outputs(input string p);
    chk({p, "_cpu_resp"}, 32'(cpu_resp), 32'h0);
    chk({p, "_req_valid"}, 32'(req_valid), 32'h0);
    chk({p, "_req_we"}, 32'(req_we), 32'h0);
    chk({p, "_error"}, 32'(error), 32'h0);
    chk({p, "_cpu_rdata"}, cpu_rdata, 32'h0);
    chk({p, "_req_addr"}, req_addr, 32'h0);
    chk({p, "_req_mask"}, 32'(req_mask), 32'h0);
    chk({p, "_req_wdata"}, req_wdata, 32'h0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    exp_err = 1'b0;
    exp_rsp_q.delete();
    exp_req_q.delete();
    @(posedge clk); #1;
  endtask

  // Issues one CPU request and waits for its resp; exp_lat <= 0 skips the latency check.
  task automatic do_req(input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, input int exp_lat, input int inject_at);
    exp_req_t q;
    exp_rsp_t r;
    bit       we;
    bit       reject;
    int       k;
    we = (wm != 4'h0);
    reject = 1'b0;
`ifdef CPU_MEM_BRIDGE_ALIGN_CHECK_EN
    reject = (addr[1:0] != 2'b00);
`endif
    if (rm != 4'h0 && wm != 4'h0) exp_err = 1'b1;
    if (inject_at > 0) exp_err = 1'b1;
    if (reject) begin
      exp_err = 1'b1;
      r.rdata = '0;
    end else begin
      q.addr = {addr[31:2], 2'b00};
      q.mask = we ? wm : rm;
      q.wdata = wd;
      q.we = we;
      exp_req_q.push_back(q);
      if (ds_no_rsp) begin
        exp_err = 1'b1;
        r.rdata = '0;
      end else if (we) begin
        r.rdata = '0;
      end else begin
        r.rdata = ref_rd(q.addr);
      end
      if (we) ref_mem[q.addr] = merge(ref_rd(q.addr), wd, wm);
    end
    r.err = exp_err;
    exp_rsp_q.push_back(r);

    cpu_addr = addr; cpu_rmask = rm; cpu_wmask = wm; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_rmask = '0; cpu_wmask = '0;
    k = 0;
    while (k < 64) begin
      @(negedge clk);
      k++;
      if (inject_at > 0 && k == inject_at) cpu_rmask = 4'hF;
      else if (inject_at > 0 && k == inject_at + 1) cpu_rmask = 4'h0;
      if (cpu_resp) break;
    end
    cpu_rmask = '0;
    if (!cpu_resp) chk("resp_timeout", 32'(cpu_resp), 32'h1);
    else if (exp_lat > 0) chk("latency", 32'(k), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] a;
    logic [3:0]  m;
    rst_n = 1'b0;
    cpu_addr = '0; cpu_rmask = '0; cpu_wmask = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    preload(32'h0000_1004, 32'hDEAD_BEEF);
    preload(32'h0000_1000, 32'h1234_5678);

    // Minimum-latency read.
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h5555_0000, 3, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
    chk("error_read", 32'(error), 32'h0);

    // Write with a 5-cycle ready stall, then read it back.
    rdy_fix = 5;
    do_req(32'h0000_2000, 4'h0, 4'b0011, 32'h0000_ABCD, 8, 0);
    rdy_fix = 0;
    do_req(32'h0000_2000, 4'hF, 4'h0, 32'h0, 3, 0);

    // Random reads and writes with random stalls.
    rdy_fix = -1;
    rsp_fix = -1;
    for (int i = 0; i < 80; i++) begin
      a = 32'h0000_3000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      m = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 0) do_req(a, m, 4'h0, $urandom, -1, 0);
      else do_req(a, 4'h0, m, $urandom, -1, 0);
    end
    chk("error_random", 32'(error), 32'h0);
    rdy_fix = 0;
    rsp_fix = 0;

    // No response: forced completion after TO cycles in WAIT_RSP.
    ds_no_rsp = 1'b1;
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, TO + 2, 0);
    ds_no_rsp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("error_sticky", 32'(error), 32'h1);

    // Both masks set: treated as a write with wmask, error raised.
    apply_reset();
    do_req(32'h0000_0040, 4'hF, 4'h1, 32'hA5A5_A5A5, 3, 0);
    chk("error_both_masks", 32'(error), 32'h1);

    // New request while waiting for the response.
    apply_reset();
    rsp_fix = 4;
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 7, 2);
    rsp_fix = 0;
    chk("error_early_req", 32'(error), 32'h1);

    // Response with nothing outstanding.
    apply_reset();
    spur_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("error_spurious_rsp", 32'(error), 32'h1);

    // Asynchronous reset while the request is stalled.
    apply_reset();
    rdy_fix = 20;
    begin
      exp_req_t q;
      q.addr = 32'h0000_1004; q.mask = 4'hF; q.wdata = 32'h0; q.we = 1'b0;
      exp_req_q.push_back(q);
    end
    cpu_addr = 32'h0000_1004; cpu_rmask = 4'hF; cpu_wmask = 4'h0; cpu_wdata = 32'h0;
    @(posedge clk); #1;
    cpu_rmask = '0;
    @(negedge clk);
    chk("req_valid_before_rst", 32'(req_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    exp_rsp_q.delete();
    exp_req_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_err = 1'b0;
    rdy_fix = 0;
    @(posedge clk); #1;
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 3, 0);
    chk("error_after_rst", 32'(error), 32'h0);

    // Misaligned address.
`ifdef CPU_MEM_BRIDGE_ALIGN_CHECK_EN
    do_req(32'h0000_1002, 4'hF, 4'h0, 32'h0, 1, 0);
    chk("error_misaligned", 32'(error), 32'h1);
`else
    do_req(32'h0000_1002, 4'hF, 4'h0, 32'h0, 3, 0);
    chk("error_misaligned", 32'(error), 32'h0);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'h0);
    chk("req_queue_empty", 32'(exp_req_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
